// File: rtl/shadow_return_stack_pkg.sv
// Shared types for the shadow return-address stack and its branch-unit producer.
// riscv holds the address width; ariane_pkg holds the stack defaults, FSM states and event bundle.
package riscv;
  localparam int unsigned VLEN = 32;
endpackage

package ariane_pkg;
  localparam int unsigned SRS_DEPTH = 16;

  typedef enum logic {SRS_IDLE, SRS_PENDING} srs_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   is_call;
    logic                   is_return;
    logic [riscv::VLEN-1:0] link_addr;
    logic [riscv::VLEN-1:0] target;
  } srs_event_t;
endpackage

// File: rtl/srs_lifo.sv
// Circular LIFO storage: when full, a push overwrites the oldest entry; popping an empty stack sets underflow.
// Simultaneous push+pop writes the slot freed by the pop, so depth and top pointer stay put.
module srs_lifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   rdata,
  output logic [PTR_W:0] depth,
  output logic           empty,
  output logic           overflow,
  output logic           underflow
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [PTR_W-1:0] top_m1;
  logic [PTR_W:0]   depth_q;
  logic             full;
  logic             do_pop;

  assign top_m1 = top_q - PTR_W'(1);
  assign empty  = (depth_q == '0);
  assign full   = (depth_q == (PTR_W+1)'(DEPTH));
  assign do_pop = pop & ~empty;
  assign rdata  = mem[top_m1];
  assign depth  = depth_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q     <= '0;
      depth_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      top_q   <= '0;
      depth_q <= '0;
    end else begin
      if (pop && empty) underflow <= 1'b1;
      if (push && !do_pop && full) overflow <= 1'b1;
      case ({push, do_pop})
        2'b10: begin
          top_q <= top_q + PTR_W'(1);
          if (!full) depth_q <= depth_q + (PTR_W+1)'(1);
        end
        2'b01: begin
          top_q   <= top_m1;
          depth_q <= depth_q - (PTR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Data array carries no reset; occupancy alone defines which slots are valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[do_pop ? top_m1 : top_q] <= wdata;
  end
endmodule

// File: rtl/shadow_return_stack.sv
// Shadow return stack: link calls push, returns pop and compare bits [VLEN-1:1] against the resolved target.
// Mismatches raise a held halt request, count saturating violations and drive the sticky LEDs.
module shadow_return_stack
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = SRS_DEPTH,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned DW   = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic                   is_call_i,
  input  logic                   is_return_i,
  input  logic [riscv::VLEN-1:0] link_addr_i,
  input  logic [riscv::VLEN-1:0] target_i,
  input  logic                   check_en_i,
  input  logic                   clear_i,
  input  logic                   halt_ack_i,
  output logic                   halt_req_o,
  output logic [riscv::VLEN-1:0] bad_target_o,
  output logic [CNT_W-1:0]       viol_cnt_o,
  output logic [DW-1:0]          depth_o,
  output logic [2:0]             led_o
);
  localparam int unsigned VLEN = riscv::VLEN;

  srs_event_t       ev;
  logic             accept;
  logic             push;
  logic             pop;
  logic [VLEN-1:0]  top_data;
  logic             stk_empty;
  logic             overflow;
  logic             underflow;
  logic             mismatch;

  srs_state_e       state_q, state_d;
  logic             retry_q, retry_d;
  logic [VLEN-1:0]  retry_tgt_q;
  logic             capture;
  logic [VLEN-1:0]  capture_tgt;
  logic [VLEN-1:0]  bad_target_q;
  logic [CNT_W-1:0] cnt_q;

  assign ev = '{valid: valid_i, is_call: is_call_i, is_return: is_return_i,
                link_addr: link_addr_i, target: target_i};

  assign accept = ev.valid & check_en_i & ~clear_i;
  assign push   = accept & ev.is_call;
  assign pop    = accept & ev.is_return;

  srs_lifo #(.DEPTH(DEPTH), .W(VLEN)) u_lifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clear     (clear_i),
    .push      (push),
    .pop       (pop),
    .wdata     (ev.link_addr),
    .rdata     (top_data),
    .depth     (depth_o),
    .empty     (stk_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Bit 0 of a JALR target is architecturally cleared, so it never counts as a mismatch.
  assign mismatch = pop & ~stk_empty & (|((top_data ^ ev.target) & ~VLEN'(1)));

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    capture     = 1'b0;
    capture_tgt = ev.target;
    case (state_q)
      SRS_IDLE: begin
        if (retry_q) begin
          state_d     = SRS_PENDING;
          capture     = 1'b1;
          capture_tgt = retry_tgt_q;
          retry_d     = 1'b0;
        end else if (mismatch) begin
          state_d = SRS_PENDING;
          capture = 1'b1;
        end
      end
      SRS_PENDING: begin
        if (halt_ack_i) begin
          state_d = SRS_IDLE;
          if (mismatch) retry_d = 1'b1;
        end
      end
      default: state_d = SRS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SRS_IDLE;
      retry_q      <= 1'b0;
      retry_tgt_q  <= '0;
      bad_target_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (retry_d && !retry_q) retry_tgt_q <= ev.target;
      if (capture) bad_target_q <= capture_tgt;
      if (mismatch && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign halt_req_o   = (state_q == SRS_PENDING);
  assign bad_target_o = bad_target_q;
  assign viol_cnt_o   = cnt_q;
  assign led_o        = {underflow, overflow, halt_req_o};
endmodule

// File: tb/tb_shadow_return_stack.sv
// Directed bench for shadow_return_stack with a queue-based reference model.
// Model state is compared against the DUT every negedge; literal checks pin key scenarios.
module tb_shadow_return_stack;
  import ariane_pkg::*;

  localparam int D  = 16;
  localparam int VL = riscv::VLEN;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          valid_i, is_call_i, is_return_i;
  logic [VL-1:0] link_addr_i, target_i;
  logic          check_en_i, clear_i, halt_ack_i;
  logic          halt_req_o;
  logic [VL-1:0] bad_target_o;
  logic [7:0]    viol_cnt_o;
  logic [4:0]    depth_o;
  logic [2:0]    led_o;

  shadow_return_stack #(.DEPTH(D), .CNT_W(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .is_call_i    (is_call_i),
    .is_return_i  (is_return_i),
    .link_addr_i  (link_addr_i),
    .target_i     (target_i),
    .check_en_i   (check_en_i),
    .clear_i      (clear_i),
    .halt_ack_i   (halt_ack_i),
    .halt_req_o   (halt_req_o),
    .bad_target_o (bad_target_o),
    .viol_cnt_o   (viol_cnt_o),
    .depth_o      (depth_o),
    .led_o        (led_o)
  );

  always #5 clk_i = ~clk_i;

  logic [VL-1:0] stk[$];
  bit            m_halt, m_retry, m_ovf, m_udf;
  logic [VL-1:0] m_bad, m_rtgt;
  int            m_cnt;
  int            total = 0;
  int            bad = 0;
  bit            cmp_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    stk.delete();
    m_halt = 0; m_retry = 0; m_ovf = 0; m_udf = 0;
    m_bad = '0; m_rtgt = '0; m_cnt = 0;
  endfunction

  function automatic void model_step(bit v, bit c, bit r, logic [VL-1:0] link,
                                     logic [VL-1:0] tgt, bit ack, bit clr, bit en);
    bit            mis = 0;
    logic [VL-1:0] e;
    if (clr) begin
      stk.delete();
    end else if (v && en) begin
      if (r) begin
        if (stk.size() > 0) begin
          e   = stk.pop_back();
          mis = ((e >> 1) != (tgt >> 1));
        end else begin
          m_udf = 1;
        end
      end
      if (c) begin
        if (stk.size() == D) begin
          void'(stk.pop_front());
          m_ovf = 1;
        end
        stk.push_back(link);
      end
    end
    if (!m_halt) begin
      if (m_retry) begin
        m_halt = 1; m_bad = m_rtgt; m_retry = 0;
      end else if (mis) begin
        m_halt = 1; m_bad = tgt;
      end
    end else if (ack) begin
      m_halt = 0;
      if (mis) begin m_retry = 1; m_rtgt = tgt; end
    end
    if (mis && m_cnt < 255) m_cnt++;
  endfunction

  task automatic step(bit v, bit c, bit r, logic [VL-1:0] link, logic [VL-1:0] tgt,
                      bit ack = 0, bit clr = 0);
    valid_i = v; is_call_i = c; is_return_i = r;
    link_addr_i = link; target_i = tgt; halt_ack_i = ack; clear_i = clr;
    @(posedge clk_i);
    model_step(v, c, r, link, tgt, ack, clr, check_en_i);
    @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("halt_req", 64'(halt_req_o), 64'(m_halt));
      chk("bad_target", 64'(bad_target_o), 64'(m_bad));
      chk("viol_cnt", 64'(viol_cnt_o), 64'(m_cnt));
      chk("depth", 64'(depth_o), 64'(stk.size()));
      chk("led", 64'(led_o), 64'({m_udf, m_ovf, m_halt}));
    end
  end

  initial begin
    rst_ni = 1'b0;
    valid_i = 0; is_call_i = 0; is_return_i = 0; link_addr_i = '0; target_i = '0;
    check_en_i = 1; clear_i = 0; halt_ack_i = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_halt", 64'(halt_req_o), 64'd0);
    chk("rst_depth", 64'(depth_o), 64'd0);
    chk("rst_led", 64'(led_o), 64'd0);
    chk("rst_cnt", 64'(viol_cnt_o), 64'd0);
    rst_ni = 1'b1;
    cmp_en = 1'b1;

    // matching call/return
    step(1, 1, 0, 32'h8000_0104, '0);
    chk("t1_depth_push", 64'(depth_o), 64'd1);
    step(1, 0, 1, '0, 32'h8000_0104);
    chk("t1_depth_pop", 64'(depth_o), 64'd0);
    chk("t1_halt", 64'(halt_req_o), 64'd0);
    chk("t1_cnt", 64'(viol_cnt_o), 64'd0);

    // mismatch, second mismatch while pending, acknowledge
    step(1, 1, 0, 32'h8000_0104, '0);
    step(1, 0, 1, '0, 32'h8000_0200);
    chk("t2_halt", 64'(halt_req_o), 64'd1);
    chk("t2_bad", 64'(bad_target_o), 64'h8000_0200);
    chk("t2_cnt", 64'(viol_cnt_o), 64'd1);
    step(1, 1, 0, 32'h8000_0300, '0);
    step(1, 0, 1, '0, 32'h8000_0400);
    chk("t2_cnt2", 64'(viol_cnt_o), 64'd2);
    chk("t2_bad_kept", 64'(bad_target_o), 64'h8000_0200);
    step(0, 0, 0, '0, '0, 1);
    chk("t2_ack", 64'(halt_req_o), 64'd0);

    // mismatch coinciding with acknowledge re-arms one cycle later
    step(1, 1, 0, 32'h8000_0500, '0);
    step(1, 0, 1, '0, 32'h8000_0600);
    step(1, 1, 0, 32'h8000_0700, '0);
    step(1, 0, 1, '0, 32'h8000_0800, 1);
    chk("t2b_drop", 64'(halt_req_o), 64'd0);
    chk("t2b_cnt", 64'(viol_cnt_o), 64'd4);
    step(0, 0, 0, '0, '0);
    chk("t2b_rearm", 64'(halt_req_o), 64'd1);
    chk("t2b_bad", 64'(bad_target_o), 64'h8000_0800);
    step(0, 0, 0, '0, '0, 1);

    // bit 0 ignored
    step(1, 1, 0, 32'h8000_0105, '0);
    step(1, 0, 1, '0, 32'h8000_0104);
    chk("bit0_cnt", 64'(viol_cnt_o), 64'd4);

    // overflow then underflow
    for (int i = 0; i < 17; i++) step(1, 1, 0, 32'h1000 + 32'(4 * i), '0);
    chk("t3_full", 64'(depth_o), 64'd16);
    chk("t3_ovf_led", 64'(led_o), 64'b010);
    for (int i = 16; i >= 1; i--) step(1, 0, 1, '0, 32'h1000 + 32'(4 * i));
    chk("t3_empty", 64'(depth_o), 64'd0);
    chk("t3_noalert", 64'(viol_cnt_o), 64'd4);
    step(1, 0, 1, '0, 32'h1234);
    chk("t3_udf_led", 64'(led_o), 64'b110);
    chk("t3_udf_cnt", 64'(viol_cnt_o), 64'd4);

    // coroutine jump
    step(1, 1, 0, 32'h8000_0010, '0);
    step(1, 1, 1, 32'h8000_0020, 32'h8000_0010);
    chk("t4_depth", 64'(depth_o), 64'd1);
    chk("t4_halt", 64'(halt_req_o), 64'd0);
    step(1, 0, 1, '0, 32'h8000_0020);
    chk("t4_pop", 64'(depth_o), 64'd0);
    chk("t4_cnt", 64'(viol_cnt_o), 64'd4);

    // checking disabled, then clear racing a push
    step(1, 1, 0, 32'h8000_0900, '0);
    check_en_i = 0;
    step(1, 0, 1, '0, 32'h8000_0aaa);
    chk("t5_depth", 64'(depth_o), 64'd1);
    chk("t5_halt", 64'(halt_req_o), 64'd0);
    check_en_i = 1;
    step(1, 1, 0, 32'h8000_0b00, '0, 0, 1);
    chk("t5_clear", 64'(depth_o), 64'd0);

    // async reset while pending with depth 5
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h2000 + 32'(4 * i), '0);
    step(1, 0, 1, '0, 32'h0000_dead);
    chk("t6_pending", 64'(halt_req_o), 64'd1);
    chk("t6_depth", 64'(depth_o), 64'd5);
    cmp_en = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_halt", 64'(halt_req_o), 64'd0);
    chk("t6_rst_bad", 64'(bad_target_o), 64'd0);
    chk("t6_rst_cnt", 64'(viol_cnt_o), 64'd0);
    chk("t6_rst_depth", 64'(depth_o), 64'd0);
    chk("t6_rst_led", 64'(led_o), 64'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    cmp_en = 1'b1;
    step(1, 1, 0, 32'h3000, '0);
    step(1, 0, 1, '0, 32'h3000);
    chk("t6_post_depth", 64'(depth_o), 64'd0);
    step(0, 0, 0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shadow_return_stack.md
# shadow_return_stack

Hardware shadow return-address stack that sits directly downstream of the branch unit and consumes its resolved control-flow events. A link call (JAL/JALR with rd = x1) pushes the plain link address. A return (JALR rd = x0, rs1 = x1) pops the shadow stack and compares the entry with the resolved (decoded) target. A mismatch raises a held halt request to the controller and is recorded for debug and the board LEDs.

## Interface
- DEPTH, 16: shadow stack entries; power of two, ≥ 2.
- CNT_W, 8: width of the saturating violation counter.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  resolved control-flow event this cycle.
- is_call_i  in  1  event is a link call (rd = x1).
- is_return_i  in  1  event is a return (rd = x0, rs1 = x1).
- link_addr_i  in  riscv::VLEN  plain next-PC of the call.
- target_i  in  riscv::VLEN  resolved, decoded return target.
- check_en_i  in  1  checking enabled: U-mode and not debug mode.
- clear_i  in  1  synchronous stack clear (trap or context switch).
- halt_ack_i  in  1  controller acknowledges the halt request.
- halt_req_o  out  1  violation pending; held until acknowledged.
- bad_target_o  out  riscv::VLEN  target of the first unacknowledged violation.
- viol_cnt_o  out  CNT_W  saturating count of mismatches.
- depth_o  out  $clog2(DEPTH)+1  current occupancy.
- led_o  out  3  [0] halt pending, [1] overflow sticky, [2] underflow sticky.

## Operation
- Events are accepted only when valid_i = 1 and check_en_i = 1. All other cycles leave the state untouched, apart from clear_i and the handshake.
- Push (is_call_i only): write link_addr_i at top, then depth += 1.
- Push when full: overwrite the oldest entry (circular) and keep depth = DEPTH. Set overflow sticky.
- Pop (is_return_i only), depth > 0: read the top entry and decrement depth. Compare bits [VLEN-1:1] of the entry against target_i; bit 0 is ignored.
- Pop when empty: no compare, no alert. Set underflow sticky.
- Both is_call_i and is_return_i set (coroutine jump): pop and compare first, then push link_addr_i into the freed slot. Depth is unchanged; when empty, depth becomes 1 and underflow is set.
- Alert FSM, states IDLE and PENDING:
  - IDLE → PENDING on a mismatch. Capture target_i into bad_target_o.
  - PENDING → IDLE on halt_ack_i.
  - A mismatch while PENDING only increments viol_cnt_o; bad_target_o is not overwritten.
  - A mismatch in the same cycle as halt_ack_i: return to IDLE, then re-enter PENDING the next cycle with the new target.
- viol_cnt_o increments on every mismatch and saturates at all-ones.
- clear_i: depth = 0 and top pointer = 0. Stickies, counter and FSM are kept. clear_i wins over a simultaneous event; that event is dropped.

## Timing
- All outputs are registered. Reset values: halt_req_o 0, bad_target_o 0, viol_cnt_o 0, depth_o 0, led_o 3'b000, FSM IDLE.
- Latency: valid_i mismatch at cycle N → halt_req_o = 1 at N+1. depth_o reflects an event at N+1.
- halt_req_o stays 1 until the cycle after halt_ack_i is sampled high. halt_ack_i while IDLE is ignored.
- Back-to-back events are accepted every cycle with no stall. A push at N followed by a pop at N+1 returns the N entry.
- An asynchronous reset mid-operation empties the stack and drops any pending alert immediately.

## Structure
- ariane_pkg holds:
  - the SRS_DEPTH default,
  - the typedef enum logic {SRS_IDLE, SRS_PENDING} srs_state_e,
  - the typedef struct srs_event_t {valid, is_call, is_return, link_addr, target}, so the branch unit can export one bundled port.
- Sub-module srs_lifo holds the storage: a circular LIFO with top pointer, depth counter, push/pop/clear and overflow/underflow flags. The parent holds the compare, FSM, counter and LEDs.
- Storage is a flop array (DEPTH × VLEN, no reset required on data). Pointers and flags are reset.

## Test plan
- Push call with link 0x8000_0104, then return with target 0x8000_0104 → no halt_req_o, depth 1 → 0, viol_cnt_o 0.
- Push 0x8000_0104, then return to 0x8000_0200 → halt_req_o = 1 next cycle, bad_target_o 0x8000_0200, viol_cnt_o 1. A second mismatch before halt_ack_i → count 2, bad_target_o unchanged. halt_ack_i → halt_req_o 0 next cycle.
- 17 pushes with DEPTH 16 → depth_o 16, led_o[1] = 1. Then 16 correct pops → no alert. A 17th pop → led_o[2] = 1, no alert.
- Combined call+return with the stack holding 0x8000_0010 and target 0x8000_0010, link 0x8000_0020 → no alert, depth unchanged. The next return to 0x8000_0020 passes.
- check_en_i = 0 (debug mode) with a mismatching return → no state change. clear_i together with a push → depth_o 0, push dropped.
- Assert rst_ni low while PENDING with depth 5 → all outputs at reset values in the same cycle, stack empty.
